// File: rtl/dcache_responder.sv
// dcache_responder: direct-mapped, write-through, no-write-allocate data cache
// between the CPU data port and a word-wide backing-memory handshake port.
//   clk, rst                          clock, synchronous active-high reset
//   cpu_addr/re/we/din -> cpu_dout    CPU request in, read data out
//   stall                             holds the pipeline while a request is serviced
//   mem_req_* (valid/ready/we/addr/mask/data)  backing request channel
//   mem_resp_valid/data               backing read data, one outstanding read max
module dcache_responder #(
  parameter int unsigned INDEX_BITS = 6,
  parameter int unsigned WORD_BITS  = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] cpu_addr,
  input  logic        cpu_re,
  input  logic [3:0]  cpu_we,
  input  logic [31:0] cpu_din,
  output logic [31:0] cpu_dout,
  output logic        stall,
  output logic        mem_req_valid,
  input  logic        mem_req_ready,
  output logic        mem_req_we,
  output logic [29:0] mem_req_addr,
  output logic [3:0]  mem_req_mask,
  output logic [31:0] mem_req_data,
  input  logic        mem_resp_valid,
  input  logic [31:0] mem_resp_data
);

  localparam int unsigned LINES    = 1 << INDEX_BITS;
  localparam int unsigned WORDS    = 1 << WORD_BITS;
  localparam int unsigned ENTRIES  = LINES * WORDS;
  localparam int unsigned TAG_BITS = 30 - INDEX_BITS - WORD_BITS;

  typedef enum logic [2:0] {IDLE, LOOKUP, FILL_REQ, FILL_WAIT, WR_REQ} state_t;

  state_t state_q, state_d;

  logic [29:0]           req_addr_q;
  logic [3:0]            req_be_q;
  logic [31:0]           req_din_q;
  logic [WORD_BITS-1:0]  fill_cnt_q;
  logic [31:0]           dout_q;
  logic [29:0]           mreq_addr_q;
  logic [3:0]            mreq_mask_q;
  logic [31:0]           mreq_data_q;
  logic [LINES-1:0]      valid_q;
  logic [TAG_BITS-1:0]   tag_q  [LINES];
  logic [31:0]           data_q [ENTRIES];

  // Byte offset is architecturally ignored
  logic [1:0] unused_addr_bits;
  assign unused_addr_bits = cpu_addr[1:0];

  logic [TAG_BITS-1:0]              req_tag;
  logic [INDEX_BITS-1:0]            req_idx;
  logic [WORD_BITS-1:0]             req_word;
  logic [INDEX_BITS+WORD_BITS-1:0]  entry_idx;
  logic [INDEX_BITS+WORD_BITS-1:0]  fill_entry;
  logic                             req_write;
  logic                             hit;
  logic [31:0]                      rd_word;

  assign req_tag    = req_addr_q[29:INDEX_BITS+WORD_BITS];
  assign req_idx    = req_addr_q[INDEX_BITS+WORD_BITS-1:WORD_BITS];
  assign req_word   = req_addr_q[WORD_BITS-1:0];
  assign entry_idx  = {req_idx, req_word};
  assign fill_entry = {req_idx, fill_cnt_q};
  assign req_write  = |req_be_q;
  assign hit        = valid_q[req_idx] && (tag_q[req_idx] == req_tag);

  // On the final fill beat the requested word may be the one arriving now
  assign rd_word = (state_q == FILL_WAIT && fill_cnt_q == req_word) ? mem_resp_data
                                                                     : data_q[entry_idx];

  logic capture, finish, rd_done, merge_en, fill_start, fill_wr, fill_last, wr_start;

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next state, stall and datapath strobes
  always_comb begin
    state_d    = state_q;
    stall      = 1'b0;
    finish     = 1'b0;
    rd_done    = 1'b0;
    merge_en   = 1'b0;
    fill_start = 1'b0;
    fill_wr    = 1'b0;
    fill_last  = 1'b0;
    wr_start   = 1'b0;
    case (state_q)
      IDLE: finish = 1'b1;
      LOOKUP: begin
        if (req_write) begin
          stall    = 1'b1;
          merge_en = hit;
          wr_start = 1'b1;
          state_d  = WR_REQ;
        end else if (hit) begin
          rd_done = 1'b1;
          finish  = 1'b1;
        end else begin
          stall      = 1'b1;
          fill_start = 1'b1;
          state_d    = FILL_REQ;
        end
      end
      FILL_REQ: begin
        stall = 1'b1;
        if (mem_req_ready) state_d = FILL_WAIT;
      end
      FILL_WAIT: begin
        stall = 1'b1;
        if (mem_resp_valid) begin
          fill_wr = 1'b1;
          if (fill_cnt_q == WORD_BITS'(WORDS - 1)) begin
            fill_last = 1'b1;
            rd_done   = 1'b1;
            stall     = 1'b0;
            finish    = 1'b1;
          end else begin
            state_d = FILL_REQ;
          end
        end
      end
      WR_REQ: begin
        if (mem_req_ready) finish = 1'b1;
        else               stall  = 1'b1;
      end
      default: state_d = IDLE;
    endcase
    capture = !stall && (cpu_re || (|cpu_we));
    if (finish) state_d = capture ? LOOKUP : IDLE;
  end

  // Request capture, read-data hold, valid bits and backing-request registers
  always_ff @(posedge clk) begin
    if (rst) begin
      req_addr_q  <= '0;
      req_be_q    <= '0;
      req_din_q   <= '0;
      fill_cnt_q  <= '0;
      dout_q      <= '0;
      mreq_addr_q <= '0;
      mreq_mask_q <= '0;
      mreq_data_q <= '0;
      valid_q     <= '0;
    end else begin
      if (capture) begin
        req_addr_q <= cpu_addr[31:2];
        req_be_q   <= cpu_we;
        req_din_q  <= cpu_din;
      end
      if (rd_done) dout_q <= rd_word;
      if (fill_start) begin
        valid_q[req_idx] <= 1'b0;
        fill_cnt_q       <= '0;
        mreq_addr_q      <= {req_tag, req_idx, WORD_BITS'(0)};
        mreq_mask_q      <= '0;
        mreq_data_q      <= '0;
      end
      if (fill_wr && !fill_last) begin
        fill_cnt_q  <= fill_cnt_q + WORD_BITS'(1);
        mreq_addr_q <= {req_tag, req_idx, fill_cnt_q + WORD_BITS'(1)};
      end
      if (fill_last) valid_q[req_idx] <= 1'b1;
      if (wr_start) begin
        mreq_addr_q <= req_addr_q;
        mreq_mask_q <= req_be_q;
        mreq_data_q <= req_din_q;
      end
    end
  end

  // Tag and data arrays; contents are meaningless while the valid bit is clear
  always_ff @(posedge clk) begin
    if (fill_wr) data_q[fill_entry] <= mem_resp_data;
    if (fill_last) tag_q[req_idx] <= req_tag;
    if (merge_en) begin
      for (int b = 0; b < 4; b++) begin
        if (req_be_q[b]) data_q[entry_idx][8*b +: 8] <= req_din_q[8*b +: 8];
      end
    end
  end

  assign cpu_dout      = rd_done ? rd_word : dout_q;
  assign mem_req_valid = (state_q == FILL_REQ) || (state_q == WR_REQ);
  assign mem_req_we    = (state_q == WR_REQ);
  assign mem_req_addr  = mreq_addr_q;
  assign mem_req_mask  = mreq_mask_q;
  assign mem_req_data  = mreq_data_q;

endmodule
